fetch_btb_stage: RTL and testbench
==================================

// Module: fetch_btb_stage
// PURPOSE
//   IF-stage PC generator with direct-mapped branch target buffer (BTB); directly upstream of IF_ID.
//   Holds the PC, drives it to instruction memory and the IF_ID pc input each cycle, and predicts next PC.
//   Produces br_sel_BTB_o / predicted_pc_o for IF_ID; EX-stage resolution writes training updates back.
// PARAMETERS
//   BTB_ENTRIES  16        entry count, power of 2, >=2; IDX_W = $clog2(BTB_ENTRIES)
//   RESET_PC     32'h0     PC loaded on reset
// PORTS
//   clk_i          in   1   clock, rising edge
//   rst_ni         in   1   reset, asynchronous, active-low
//   enable_i       in   1   1 = advance PC; 0 = stall (hold PC)
//   redirect_i     in   1   mispredict/flush from EX; forces PC load
//   redirect_pc_i  in   32  corrected PC for redirect_i
//   upd_valid_i    in   1   BTB training update strobe (resolved branch/jump)
//   upd_pc_i       in   32  PC of resolved branch
//   upd_target_i   in   32  resolved target
//   upd_taken_i    in   1   resolved direction
//   pc_o           out  32  current fetch PC (imem address, to IF_ID pc_i)
//   br_sel_BTB_o   out  1   1 = BTB predicts taken for pc_o
//   predicted_pc_o out  32  predicted next PC (to IF_ID predicted_pc_i)
// BEHAVIOUR
//   Reset (async on rst_ni=0): pc_o=RESET_PC; all valid bits=0; counters=2'b01; tags/targets=0.
//     Consequently br_sel_BTB_o=0, predicted_pc_o=RESET_PC+4 during/after reset.
//   Entry: {valid, tag[31-IDX_W-2:0], target[31:0], cnt[1:0]}; idx=pc[IDX_W+1:2], tag=pc[31:IDX_W+2].
//   Lookup, combinational on pc_o (zero latency):
//     hit = valid[idx] && tag[idx]==pc_o tag; br_sel_BTB_o = hit && cnt[idx][1].
//     predicted_pc_o = br_sel_BTB_o ? target[idx] : pc_o+32'd4 (mod 2^32; 32'hFFFFFFFC -> 32'h0).
//   PC register, rising edge, priority order:
//     1 redirect_i          -> pc <= redirect_pc_i (regardless of enable_i)
//     2 enable_i            -> pc <= predicted_pc_o
//     3 otherwise           -> hold
//   Update, rising edge when upd_valid_i (independent of enable_i/redirect_i):
//     uhit = valid & tag match at upd idx (upd_pc_i bits[1:0] ignored).
//     taken & uhit  : target<=upd_target_i; cnt saturating +1 (max 2'b11).
//     taken & !uhit : allocate/replace: valid<=1, tag, target, cnt<=2'b10.
//     !taken & uhit : cnt saturating -1 (min 2'b00); target unchanged.
//     !taken & !uhit: no change (no allocation on not-taken).
//   Same-cycle lookup/update on same entry: lookup uses pre-update contents; new state visible next cycle.
//   Reset asserted mid-operation: PC and BTB state abort to reset values immediately; pending update lost.
//   No internal handshake state; stall/flush of IF_ID is owned by hazard unit, not this block.
// CONFIGURATION
//   FETCH_BTB_EN defined  : BTB storage/update logic built as above.
//   FETCH_BTB_EN undefined: no BTB storage; br_sel_BTB_o=0, predicted_pc_o=pc_o+4 always;
//     upd_* inputs ignored; PC register and redirect/stall behaviour unchanged.
// TESTING (BTB_ENTRIES=16, RESET_PC=0, FETCH_BTB_EN defined unless stated)
//   Reset: rst_ni=0 -> pc_o=0, br_sel=0, predicted=0x4; release, enable=1 -> pc_o 0x4,0x8,0xC on successive edges.
//   Stall/redirect: enable=0 at pc_o=0x8 for 3 cycles -> holds 0x8; redirect_i=1,redirect_pc_i=0x100,enable=0 -> pc_o=0x100 next edge.
//   Allocate: upd pc=0x10,target=0x40,taken=1; later pc_o=0x10 -> br_sel=1, predicted=0x40, next pc_o=0x40.
//   Hysteresis: after alloc (cnt=10) one not-taken -> 01, pc_o=0x10 gives br_sel=0, predicted=0x14; two taken -> 11; one not-taken -> 10, still br_sel=1.
//   Alias/wrap: entry at 0x10; pc_o=0x50 (same idx 4, diff tag) -> br_sel=0, predicted=0x54; pc_o=0xFFFFFFFC miss -> predicted=0x0.
//   Macro off: repeat allocate test without FETCH_BTB_EN -> br_sel=0, pc_o=0x10 then 0x14.

Source files
------------

// File: rtl/fetch_btb_stage_if.sv
// Fetch-stage bus: stall/redirect control and BTB training from EX, fetch PC and prediction out to IF_ID.
// The slave modport is the fetch stage; the master modport is the side driving it.
interface fetch_btb_stage_if;
  logic        enable_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_taken_i;
  logic [31:0] pc_o;
  logic        br_sel_BTB_o;
  logic [31:0] predicted_pc_o;

  modport slave (
    input  enable_i, redirect_i, redirect_pc_i,
    input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
    output pc_o, br_sel_BTB_o, predicted_pc_o
  );

  modport master (
    output enable_i, redirect_i, redirect_pc_i,
    output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
    input  pc_o, br_sel_BTB_o, predicted_pc_o
  );
endinterface

// File: rtl/fetch_btb_stage.sv
// IF-stage PC generator with a direct-mapped BTB and 2-bit saturating direction counters.
// Define FETCH_BTB_EN to build the BTB; without it the stage always predicts pc+4.
module fetch_btb_stage #(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input logic               clk_i,
  input logic               rst_ni,
  fetch_btb_stage_if.slave  bus
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic        br_sel;
  logic [31:0] predicted_pc;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_BTB_EN
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       cnt;
  } btb_entry_t;

  btb_entry_t btb_q [BTB_ENTRIES];

  logic [IDX_W-1:0] lkp_idx;
  logic [TAG_W-1:0] lkp_tag;
  logic             lkp_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             unused_upd_lsb;

  assign lkp_idx = pc_q[IDX_W+1:2];
  assign lkp_tag = pc_q[31:IDX_W+2];
  assign lkp_hit = btb_q[lkp_idx].valid && (btb_q[lkp_idx].tag == lkp_tag);
  assign br_sel  = lkp_hit && btb_q[lkp_idx].cnt[1];

  assign predicted_pc = br_sel ? btb_q[lkp_idx].target : pc_plus4;

  // Word-aligned PCs: the low two bits of the training PC carry no index or tag information.
  assign upd_idx        = bus.upd_pc_i[IDX_W+1:2];
  assign upd_tag        = bus.upd_pc_i[31:IDX_W+2];
  assign upd_hit        = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);
  assign unused_upd_lsb = ^bus.upd_pc_i[1:0];

  // NOTE: the table is cleared in full on reset because a stale valid bit would produce
  // a wrong prediction; the lookup then sees pre-update contents because writes are non-blocking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: 2'b01};
      end
    end else if (bus.upd_valid_i) begin
      if (bus.upd_taken_i) begin
        if (upd_hit) begin
          btb_q[upd_idx].target <= bus.upd_target_i;
          if (btb_q[upd_idx].cnt != 2'b11) btb_q[upd_idx].cnt <= btb_q[upd_idx].cnt + 2'd1;
        end else begin
          btb_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: bus.upd_target_i, cnt: 2'b10};
        end
      end else if (upd_hit && (btb_q[upd_idx].cnt != 2'b00)) begin
        btb_q[upd_idx].cnt <= btb_q[upd_idx].cnt - 2'd1;
      end
    end
  end
`else
  logic unused_upd;

  assign br_sel       = 1'b0;
  assign predicted_pc = pc_plus4;
  assign unused_upd   = ^{bus.upd_valid_i, bus.upd_pc_i, bus.upd_target_i, bus.upd_taken_i};
`endif

  // NOTE: the always_comb assigns a default first so no path through it can infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_i)    pc_d = bus.redirect_pc_i;
    else if (bus.enable_i) pc_d = predicted_pc;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign bus.pc_o           = pc_q;
  assign bus.br_sel_BTB_o   = br_sel;
  assign bus.predicted_pc_o = predicted_pc;

endmodule

// File: tb/tb_fetch_btb_stage.sv
// Directed bench for fetch_btb_stage: reset, stall/redirect, allocation, hysteresis, aliasing and wrap.
// Expectations follow FETCH_BTB_EN so the same bench covers both builds.
module tb_fetch_btb_stage;

`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni;
  int   vectors = 0;
  int   errors  = 0;

  fetch_btb_stage_if bus ();

  fetch_btb_stage #(.BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // Outputs are sampled and inputs changed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc, input logic sel, input logic [31:0] pred);
    vectors++;
    if (bus.pc_o !== pc) begin
      errors++; $display("FAIL %s pc_o: got %h expected %h", name, bus.pc_o, pc);
    end
    vectors++;
    if (bus.br_sel_BTB_o !== sel) begin
      errors++; $display("FAIL %s br_sel: got %b expected %b", name, bus.br_sel_BTB_o, sel);
    end
    vectors++;
    if (bus.predicted_pc_o !== pred) begin
      errors++; $display("FAIL %s predicted: got %h expected %h", name, bus.predicted_pc_o, pred);
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = pc;
    tick();
    bus.redirect_i    = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    bus.upd_valid_i  = 1'b1;
    bus.upd_pc_i     = pc;
    bus.upd_target_i = tgt;
    bus.upd_taken_i  = taken;
    tick();
    bus.upd_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    bus.enable_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = '0;
    bus.upd_valid_i = 1'b0; bus.upd_pc_i = '0; bus.upd_target_i = '0; bus.upd_taken_i = 1'b0;
    #3;
    expect_out("reset", 32'h0, 1'b0, 32'h4);
    #4 rst_ni = 1'b1;
    bus.enable_i = 1'b1;
    tick(); expect_out("run0", 32'h4, 1'b0, 32'h8);
    tick(); expect_out("run1", 32'h8, 1'b0, 32'hC);
    tick(); expect_out("run2", 32'hC, 1'b0, 32'h10);
  endtask

  task automatic test_stall_redirect();
    bus.enable_i = 1'b0;
    redirect_to(32'h8);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("stall", 32'h8, 1'b0, 32'hC);
    end
    redirect_to(32'h100);
    expect_out("redirect_stalled", 32'h100, 1'b0, 32'h104);
    bus.enable_i = 1'b1;
    redirect_to(32'h200);
    expect_out("redirect_over_enable", 32'h200, 1'b0, 32'h204);
    bus.enable_i = 1'b0;
  endtask

  task automatic test_allocate();
    train(32'h10, 32'h40, 1'b1);
    redirect_to(32'h10);
    expect_out("alloc_hit", 32'h10, BTB_ON, BTB_ON ? 32'h40 : 32'h14);
    bus.enable_i = 1'b1;
    tick();
    bus.enable_i = 1'b0;
    vectors++;
    if (bus.pc_o !== (BTB_ON ? 32'h40 : 32'h14)) begin
      errors++; $display("FAIL alloc_follow pc_o: got %h expected %h", bus.pc_o, BTB_ON ? 32'h40 : 32'h14);
    end
  endtask

  task automatic test_hysteresis();
    redirect_to(32'h10);
    // Not-taken update while pointing at the entry: this cycle still sees counter 10.
    bus.upd_valid_i = 1'b1; bus.upd_pc_i = 32'h10; bus.upd_target_i = 32'h0; bus.upd_taken_i = 1'b0;
    expect_out("same_cycle_pre", 32'h10, BTB_ON, BTB_ON ? 32'h40 : 32'h14);
    tick();
    bus.upd_valid_i = 1'b0;
    expect_out("cnt01", 32'h10, 1'b0, 32'h14);
    train(32'h10, 32'h40, 1'b1);
    expect_out("cnt10", 32'h10, BTB_ON, BTB_ON ? 32'h40 : 32'h14);
    train(32'h10, 32'h44, 1'b1);
    expect_out("cnt11_retarget", 32'h10, BTB_ON, BTB_ON ? 32'h44 : 32'h14);
    train(32'h10, 32'h0, 1'b0);
    expect_out("cnt11_to_10", 32'h10, BTB_ON, BTB_ON ? 32'h44 : 32'h14);
    // Low PC bits of the training address are ignored.
    train(32'h13, 32'h0, 1'b0);
    expect_out("cnt10_to_01_lsb", 32'h10, 1'b0, 32'h14);
  endtask

  task automatic test_alias_wrap();
    train(32'h10, 32'h48, 1'b1);
    redirect_to(32'h50);
    expect_out("alias_miss", 32'h50, 1'b0, 32'h54);
    train(32'h20, 32'h90, 1'b0);
    redirect_to(32'h20);
    expect_out("no_alloc_not_taken", 32'h20, 1'b0, 32'h24);
    redirect_to(32'hFFFF_FFFC);
    expect_out("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    bus.enable_i = 1'b1;
    tick();
    bus.enable_i = 1'b0;
    expect_out("wrap_follow", 32'h0, 1'b0, 32'h4);
    train(32'h50, 32'h80, 1'b1);
    redirect_to(32'h50);
    expect_out("replace_new", 32'h50, BTB_ON, BTB_ON ? 32'h80 : 32'h54);
    redirect_to(32'h10);
    expect_out("replace_old", 32'h10, 1'b0, 32'h14);
  endtask

  task automatic test_reset_mid();
    redirect_to(32'h50);
    bus.upd_valid_i = 1'b1; bus.upd_pc_i = 32'h50; bus.upd_target_i = 32'h84; bus.upd_taken_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    expect_out("reset_mid", 32'h0, 1'b0, 32'h4);
    @(posedge clk_i);
    #2 bus.upd_valid_i = 1'b0;
    rst_ni = 1'b1;
    redirect_to(32'h50);
    expect_out("reset_cleared_btb", 32'h50, 1'b0, 32'h54);
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_allocate();
    test_hysteresis();
    test_alias_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
